// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - state encoding, character codes, glyph ROM and message tables for the status display
package ssd_pkg;

  localparam int WIN_LEN  = 7;
  localparam int DRAW_LEN = 4;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_WIN  = 2'd1,
    ST_DRAW = 2'd2
  } state_e;

  typedef enum logic [4:0] {
    CH_0     = 5'd0,
    CH_1     = 5'd1,
    CH_2     = 5'd2,
    CH_3     = 5'd3,
    CH_4     = 5'd4,
    CH_5     = 5'd5,
    CH_6     = 5'd6,
    CH_7     = 5'd7,
    CH_8     = 5'd8,
    CH_9     = 5'd9,
    CH_P     = 5'd10,
    CH_U     = 5'd11,
    CH_I     = 5'd12,
    CH_N     = 5'd13,
    CH_D     = 5'd14,
    CH_R     = 5'd15,
    CH_A     = 5'd16,
    CH_BLANK = 5'd31
  } char_e;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] glyph(input char_e c);
    case (c)
      CH_0:    glyph = 7'b1000000;
      CH_1:    glyph = 7'b1111001;
      CH_2:    glyph = 7'b0100100;
      CH_3:    glyph = 7'b0110000;
      CH_4:    glyph = 7'b0011001;
      CH_5:    glyph = 7'b0010010;
      CH_6:    glyph = 7'b0000010;
      CH_7:    glyph = 7'b1111000;
      CH_8:    glyph = 7'b0000000;
      CH_9:    glyph = 7'b0010000;
      CH_P:    glyph = 7'b0001100;
      CH_U:    glyph = 7'b1000001;
      CH_I:    glyph = 7'b1001111;
      CH_N:    glyph = 7'b0101011;
      CH_D:    glyph = 7'b0100001;
      CH_R:    glyph = 7'b0101111;
      CH_A:    glyph = 7'b0001000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  function automatic state_e state_from_game(input logic [1:0] gs);
    case (gs)
      2'b01:   state_from_game = ST_WIN;
      2'b10:   state_from_game = ST_DRAW;
      default: state_from_game = ST_PLAY;
    endcase
  endfunction

  function automatic char_e player_char(input logic [1:0] p);
    case (p)
      2'd0:    player_char = CH_0;
      2'd1:    player_char = CH_1;
      2'd2:    player_char = CH_2;
      default: player_char = CH_3;
    endcase
  endfunction

  // Indices past the message length fall into the blank padding
  function automatic char_e win_char(input logic [4:0] k, input logic [1:0] winner);
    case (k)
      5'd0:       win_char = CH_P;
      5'd1:       win_char = player_char(winner);
      5'd3, 5'd4: win_char = CH_U;
      5'd5:       win_char = CH_I;
      5'd6:       win_char = CH_N;
      default:    win_char = CH_BLANK;
    endcase
  endfunction

  function automatic char_e draw_char(input logic [4:0] k);
    case (k)
      5'd0:    draw_char = CH_D;
      5'd1:    draw_char = CH_R;
      5'd2:    draw_char = CH_A;
      5'd3:    draw_char = CH_U;
      default: draw_char = CH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - one-cycle pulse every DIV enabled cycles; counter held at zero while disabled
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/ssd_status_ctrl.sv
// rtl/ssd_status_ctrl.sv - registered seven-segment status controller with scrolling win and blinking draw messages
module ssd_status_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int CLK_HZ     = 50000000,
  parameter int SCROLL_HZ  = 4,
  parameter int BLINK_HZ   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              turn,
  input  logic [1:0]              game_state,
  output logic [7*NUM_DIGITS-1:0] ssd_bus
);

  localparam int WIN_L  = WIN_LEN + NUM_DIGITS;
  localparam int DRAW_L = DRAW_LEN + NUM_DIGITS;
  localparam int OW     = $clog2(WIN_L);
  localparam bit WIN_SCROLLS  = (WIN_LEN > NUM_DIGITS);
  localparam bit DRAW_SCROLLS = (DRAW_LEN > NUM_DIGITS);

  state_e                  r_state;
  logic [OW-1:0]           r_offset;
  logic                    r_phase;
  logic [1:0]              r_winner;
  logic [7*NUM_DIGITS-1:0] r_ssd;

  state_e                  w_next_state;
  logic                    w_change;
  logic                    w_scrolls;
  logic                    w_scroll_en;
  logic                    w_blink_en;
  logic                    w_scroll_tick;
  logic                    w_blink_tick;
  logic [OW-1:0]           w_last;
  logic [7*NUM_DIGITS-1:0] w_ssd;

  assign w_next_state = state_from_game(game_state);
  assign w_change     = (w_next_state != r_state);
  assign w_scrolls    = (r_state == ST_WIN && WIN_SCROLLS) || (r_state == ST_DRAW && DRAW_SCROLLS);
  // Disabling the counters on a state change drops any coincident tick and restarts them from 0
  assign w_scroll_en  = !w_change && (r_state == ST_WIN || (r_state == ST_DRAW && DRAW_SCROLLS));
  assign w_blink_en   = !w_change && (r_state == ST_DRAW);
  assign w_last       = (r_state == ST_DRAW) ? OW'(DRAW_L - 1) : OW'(WIN_L - 1);

  tick_gen #(.DIV(CLK_HZ / SCROLL_HZ)) u_scroll_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (w_scroll_en),
    .tick (w_scroll_tick)
  );

  tick_gen #(.DIV(CLK_HZ / BLINK_HZ)) u_blink_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (w_blink_en),
    .tick (w_blink_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_PLAY;
      r_offset <= '0;
      r_phase  <= 1'b1;
      r_winner <= 2'd0;
    end else if (w_change) begin
      r_state  <= w_next_state;
      r_offset <= '0;
      r_phase  <= 1'b1;
      if (w_next_state == ST_WIN) begin
        r_winner <= turn;
      end
    end else begin
      if (w_scroll_tick && w_scrolls) begin
        r_offset <= (r_offset == w_last) ? '0 : r_offset + 1'b1;
      end
      if (w_blink_tick) begin
        r_phase <= ~r_phase;
      end
    end
  end

  // offset < L and digit < L, so one conditional subtract gives (offset+digit) mod L
  function automatic char_e digit_char(input state_e st, input logic [OW-1:0] off, input int digit,
                                       input logic [1:0] winner, input logic [1:0] cur_turn);
    logic [4:0] len;
    logic [4:0] idx;
    len = (st == ST_DRAW) ? 5'(DRAW_L) : 5'(WIN_L);
    idx = 5'(off) + 5'(digit);
    if (idx >= len) begin
      idx = idx - len;
    end
    case (st)
      ST_WIN:  digit_char = win_char(idx, winner);
      ST_DRAW: digit_char = draw_char(idx);
      default: digit_char = (digit == 0) ? player_char(cur_turn) : CH_BLANK;
    endcase
  endfunction

  always_comb begin
    w_ssd = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_ssd[7*i +: 7] = glyph(digit_char(r_state, r_offset, i, r_winner, turn));
    end
    if (r_state == ST_DRAW && !r_phase) begin
      w_ssd = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ssd <= '1;
    end else begin
      r_ssd <= w_ssd;
    end
  end

  assign ssd_bus = r_ssd;

endmodule

// File: tb/tb_ssd_status_ctrl.sv
// tb/tb_ssd_status_ctrl.sv - directed bench for ssd_status_ctrl at 5 and 3 digits
module tb_ssd_status_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        n_rst;
  logic [1:0]  turn;
  logic [1:0]  gs;
  logic [1:0]  n_turn;
  logic [1:0]  n_gs;
  logic [34:0] ssd;
  logic [20:0] n_ssd;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  ssd_status_ctrl #(.NUM_DIGITS(5), .CLK_HZ(40), .SCROLL_HZ(4), .BLINK_HZ(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .turn       (turn),
    .game_state (gs),
    .ssd_bus    (ssd)
  );

  ssd_status_ctrl #(.NUM_DIGITS(3), .CLK_HZ(40), .SCROLL_HZ(4), .BLINK_HZ(2)) dut_narrow (
    .clk        (clk),
    .rst        (n_rst),
    .turn       (n_turn),
    .game_state (n_gs),
    .ssd_bus    (n_ssd)
  );

  function automatic logic [6:0] seg(input byte c);
    case (c)
      "0":     seg = 7'b1000000;
      "1":     seg = 7'b1111001;
      "2":     seg = 7'b0100100;
      "3":     seg = 7'b0110000;
      "P":     seg = 7'b0001100;
      "U":     seg = 7'b1000001;
      "I":     seg = 7'b1001111;
      "n":     seg = 7'b0101011;
      "d":     seg = 7'b0100001;
      "r":     seg = 7'b0101111;
      "A":     seg = 7'b0001000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  // Character i of s lands on digit i; missing characters are blank
  function automatic logic [55:0] exp_bus(input string s);
    logic [55:0] b;
    b = '1;
    for (int i = 0; i < s.len(); i++) b[7*i +: 7] = seg(s[i]);
    return b;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [55:0] e;
    rst = 1'b1; n_rst = 1'b1; gs = 2'b01; turn = 2'd0; n_gs = 2'b00; n_turn = 2'd0;
    step(1);
    total++;
    if (ssd !== 35'h7_FFFF_FFFF) begin bad++; $display("FAIL reset_c1 got=%h want=%h", ssd, 35'h7_FFFF_FFFF); end
    step(1);
    total++;
    if (ssd !== 35'h7_FFFF_FFFF) begin bad++; $display("FAIL reset_c2 got=%h want=%h", ssd, 35'h7_FFFF_FFFF); end
    rst = 1'b0;
    step(2);
    e = exp_bus("P0 UU");
    total++;
    if (ssd !== e[34:0]) begin bad++; $display("FAIL reset_win_entry got=%h want=%h", ssd, e[34:0]); end
  endtask

  task automatic test_play;
    logic [55:0] e;
    gs = 2'b00; turn = 2'd2;
    step(2);
    e = exp_bus("2");
    total++;
    if (ssd !== e[34:0]) begin bad++; $display("FAIL play_turn2 got=%h want=%h", ssd, e[34:0]); end
    total++;
    if (ssd[6:0] !== 7'b0100100) begin bad++; $display("FAIL play_digit0_2 got=%b want=%b", ssd[6:0], 7'b0100100); end
    turn = 2'd1;
    step(2);
    e = exp_bus("1");
    total++;
    if (ssd !== e[34:0]) begin bad++; $display("FAIL play_turn1 got=%h want=%h", ssd, e[34:0]); end
  endtask

  task automatic test_win_scroll;
    logic [55:0] e;
    int    at[5] = '{2, 11, 12, 112, 122};
    string w[5]  = '{"P1 UU", "P1 UU", "1 UUI", " P1 U", "P1 UU"};
    int    now = 0;
    gs = 2'b01; turn = 2'd1;
    for (int k = 0; k < 5; k++) begin
      step(at[k] - now);
      now = at[k];
      e = exp_bus(w[k]);
      total++;
      if (ssd !== e[34:0]) begin bad++; $display("FAIL win_scroll[%0d] cyc=%0d got=%h want=%h", k, now, ssd, e[34:0]); end
      if (k == 0) turn = 2'd2;
    end
    gs = 2'b00; turn = 2'd1;
    step(2);
  endtask

  task automatic test_draw_blink;
    logic [55:0] e;
    int    at[5] = '{2, 21, 22, 41, 42};
    string w[5]  = '{"drAU", "drAU", "", "", "drAU"};
    int    now = 0;
    gs = 2'b10;
    for (int k = 0; k < 5; k++) begin
      step(at[k] - now);
      now = at[k];
      e = exp_bus(w[k]);
      total++;
      if (ssd !== e[34:0]) begin bad++; $display("FAIL draw_blink[%0d] cyc=%0d got=%h want=%h", k, now, ssd, e[34:0]); end
    end
    step(65 - now);
    e = exp_bus("");
    total++;
    if (ssd !== e[34:0]) begin bad++; $display("FAIL draw_mid_blank got=%h want=%h", ssd, e[34:0]); end
    gs = 2'b00;
    step(2);
    e = exp_bus("1");
    total++;
    if (ssd !== e[34:0]) begin bad++; $display("FAIL draw_exit_play got=%h want=%h", ssd, e[34:0]); end
    gs = 2'b10;
    step(2);
    e = exp_bus("drAU");
    total++;
    if (ssd !== e[34:0]) begin bad++; $display("FAIL draw_phase_restored got=%h want=%h", ssd, e[34:0]); end
    gs = 2'b00;
    step(2);
  endtask

  task automatic test_collision;
    logic [55:0] e;
    gs = 2'b01; turn = 2'd1;
    step(10);
    e = exp_bus("P1 UU");
    total++;
    if (ssd !== e[34:0]) begin bad++; $display("FAIL coll_pre got=%h want=%h", ssd, e[34:0]); end
    gs = 2'b10;
    step(2);
    e = exp_bus("drAU");
    total++;
    if (ssd !== e[34:0]) begin bad++; $display("FAIL coll_offset got=%h want=%h", ssd, e[34:0]); end
    step(19);
    total++;
    if (ssd !== e[34:0]) begin bad++; $display("FAIL coll_blink_on got=%h want=%h", ssd, e[34:0]); end
    step(1);
    e = exp_bus("");
    total++;
    if (ssd !== e[34:0]) begin bad++; $display("FAIL coll_blink_off got=%h want=%h", ssd, e[34:0]); end
    gs = 2'b00;
    step(2);
  endtask

  task automatic test_narrow;
    logic [55:0] e;
    int    at[6] = '{2, 12, 21, 22, 52, 82};
    string w[6]  = '{"drA", "rAU", "rAU", "", "  d", "rAU"};
    int    now = 0;
    n_gs = 2'b10; n_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(at[k] - now);
      now = at[k];
      e = exp_bus(w[k]);
      total++;
      if (n_ssd !== e[20:0]) begin bad++; $display("FAIL narrow_draw[%0d] cyc=%0d got=%h want=%h", k, now, n_ssd, e[20:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_play();
    test_win_scroll();
    test_draw_blink();
    test_collision();
    test_narrow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
